// File: rtl/vectorgen_seq_ctrl_pkg.sv
// vectorgen_seq_ctrl_pkg: shared states, ctrl bit indices
// and kernel-row bound helpers for the vectorgen sequencer.
package vectorgen_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    GAP,
    RUN,
    POST,
    NEXTFM,
    DRAIN
  } state_e;

  localparam int CTRL_NEXTFM   = 0;
  localparam int CTRL_START    = 1;
  localparam int CTRL_ENDROW   = 2;
  localparam int CTRL_SKIP_DD  = 3;
  localparam int CTRL_NEXTROW  = 4;
  localparam int CTRL_SHIFT_DD = 5;
  localparam int CTRL_POP_DD   = 6;
  localparam int CTRL_READDATA = 7;
  localparam int CTRL_NEXTDATA = 8;

  localparam int DRAIN_CYCLES = 6;
  localparam int DLY_DEPTH    = 2;

  // lowest kernel row touched by input row ih
  function automatic int kh_lo(int ih, int kh);
    return (ih > kh - 1) ? 0 : kh - 1 - ih;
  endfunction

  // highest kernel row touched by input row ih
  function automatic int kh_hi(int ih, int kh, int oh);
    return (ih > oh - 1) ? kh - 1 - (ih - oh + 1)
                         : kh - 1;
  endfunction

endpackage

// File: rtl/vectorgen_seq_ctrl_delay.sv
// vectorgen_seq_ctrl_delay: fixed-depth register delay line
// aligning pop/shift/skip with vectorgen data latency.
module vectorgen_seq_ctrl_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  // shift every stage forward by one
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // pipeline registers, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/vectorgen_seq_ctrl.sv
// vectorgen_seq_ctrl: per-layer sequencer for vectorgen ctrl.
// Define VECGEN_SEQ_STALL_EN to add the RUN stall input.
module vectorgen_seq_ctrl
  import vectorgen_seq_ctrl_pkg::*;
#(
  parameter int NUM_PE        = 4,
  parameter int DIM_W         = 10,
  parameter int KER_W         = 4,
  parameter int PAD_WIDTH     = 3,
  parameter int VECGEN_CTRL_W = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DIM_W-1:0]         cfg_ih,
  input  logic [DIM_W-1:0]         cfg_ow,
  input  logic [KER_W-1:0]         cfg_kw,
  input  logic [KER_W-1:0]         cfg_kh,
  input  logic [PAD_WIDTH-1:0]     cfg_pad,
  input  logic                     ready,
`ifdef VECGEN_SEQ_STALL_EN
  input  logic                     stall,
`endif
  output logic [VECGEN_CTRL_W-1:0] ctrl,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  state_e state_q, state_d;

  logic [DIM_W-1:0] ih_q, ih_d;
  logic [DIM_W-1:0] ow_q, ow_d;
  logic [KER_W-1:0] kh_q, kh_d;
  logic [KER_W-1:0] kw_q, kw_d;
  logic [2:0]       drn_q, drn_d;

  logic [DIM_W-1:0] c_ih_q, c_ih_d;
  logic [DIM_W-1:0] c_owt_q, c_owt_d;
  logic [DIM_W-1:0] c_oh_q, c_oh_d;
  logic [KER_W-1:0] c_kh_q, c_kh_d;
  logic [KER_W-1:0] c_kw_q, c_kw_d;
  logic             c_skip_q, c_skip_d;

  logic [VECGEN_CTRL_W-1:0] raw_q, raw_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic [DIM_W-1:0] owt_in, ow_rem;
  logic             cfg_bad, skip_in;

  logic [KER_W-1:0] lo_c, hi_c, hi_nx;
  logic last_kw, last_ow, last_ih, at_lo;
  logic pop, first, rd, run_go;

  logic [2:0] dly_d, dly_q;

`ifdef VECGEN_SEQ_STALL_EN
  assign run_go = ~stall;
`else
  assign run_go = 1'b1;
`endif

  // derive tile count, skip enable and config validity
  always_comb begin
    owt_in  = cfg_ow / DIM_W'(NUM_PE);
    ow_rem  = cfg_ow % DIM_W'(NUM_PE);
    skip_in = (int'(cfg_kw) - 2 * int'(cfg_pad)) > NUM_PE;
    cfg_bad = (DIM_W'(cfg_kh) > cfg_ih) ||
              (cfg_kh == '0) ||
              (cfg_kw == '0) ||
              (owt_in == '0) ||
              (ow_rem != '0);
  end

  // loop position decode for the current iteration
  always_comb begin
    lo_c  = KER_W'(kh_lo(int'(ih_q), int'(c_kh_q)));
    hi_c  = KER_W'(kh_hi(int'(ih_q), int'(c_kh_q),
                         int'(c_oh_q)));
    hi_nx = KER_W'(kh_hi(int'(ih_q) + 1, int'(c_kh_q),
                         int'(c_oh_q)));
    last_kw = (kw_q == c_kw_q - 1'b1);
    last_ow = (ow_q == c_owt_q - 1'b1);
    last_ih = (ih_q == c_ih_q - 1'b1);
    at_lo   = (kh_q == lo_c);
    pop     = (kw_q == '0);
    first   = pop && (kh_q == hi_c);
    rd      = first && !((ih_q == '0) && (ow_q == '0));
  end

  // next state, loop counters and raw ctrl terms
  always_comb begin
    state_d  = state_q;
    ih_d     = ih_q;
    ow_d     = ow_q;
    kh_d     = kh_q;
    kw_d     = kw_q;
    drn_d    = drn_q;
    c_ih_d   = c_ih_q;
    c_owt_d  = c_owt_q;
    c_oh_d   = c_oh_q;
    c_kh_d   = c_kh_q;
    c_kw_d   = c_kw_q;
    c_skip_d = c_skip_q;
    raw_d    = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            c_ih_d   = cfg_ih;
            c_owt_d  = owt_in;
            c_oh_d   = cfg_ih - DIM_W'(cfg_kh)
                       + DIM_W'(1);
            c_kh_d   = cfg_kh;
            c_kw_d   = cfg_kw;
            c_skip_d = skip_in;
            state_d  = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        raw_d[CTRL_START] = 1'b1;
        if (ready) state_d = GAP;
      end
      GAP: begin
        ih_d    = '0;
        ow_d    = '0;
        kw_d    = '0;
        kh_d    = c_kh_q - 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (run_go) begin
          raw_d[CTRL_POP_DD]   = pop;
          raw_d[CTRL_SHIFT_DD] = !pop;
          raw_d[CTRL_SKIP_DD]  = pop && at_lo && last_ow
                                 && !last_ih && c_skip_q;
          raw_d[CTRL_NEXTROW]  = first && (ow_q == '0)
                                 && (ih_q != '0);
          raw_d[CTRL_READDATA] = rd;
          raw_d[CTRL_ENDROW]   = rd && last_ow;
          raw_d[CTRL_NEXTDATA] = rd && !(last_ih && last_ow);
          if (!last_kw) begin
            kw_d = kw_q + 1'b1;
          end else begin
            kw_d = '0;
            if (!at_lo) begin
              kh_d = kh_q - 1'b1;
            end else if (!last_ow) begin
              ow_d = ow_q + 1'b1;
              kh_d = hi_c;
            end else if (!last_ih) begin
              ow_d = '0;
              ih_d = ih_q + 1'b1;
              kh_d = hi_nx;
            end else begin
              state_d = POST;
            end
          end
        end
      end
      POST: begin
        state_d = NEXTFM;
      end
      NEXTFM: begin
        raw_d[CTRL_NEXTFM] = 1'b1;
        drn_d   = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (drn_q == 3'(DRAIN_CYCLES - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // state, counters, latched config and ctrl register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ih_q     <= '0;
      ow_q     <= '0;
      kh_q     <= '0;
      kw_q     <= '0;
      drn_q    <= '0;
      c_ih_q   <= '0;
      c_owt_q  <= '0;
      c_oh_q   <= '0;
      c_kh_q   <= '0;
      c_kw_q   <= '0;
      c_skip_q <= 1'b0;
      raw_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ih_q     <= ih_d;
      ow_q     <= ow_d;
      kh_q     <= kh_d;
      kw_q     <= kw_d;
      drn_q    <= drn_d;
      c_ih_q   <= c_ih_d;
      c_owt_q  <= c_owt_d;
      c_oh_q   <= c_oh_d;
      c_kh_q   <= c_kh_d;
      c_kw_q   <= c_kw_d;
      c_skip_q <= c_skip_d;
      raw_q    <= raw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign dly_d = {raw_q[CTRL_POP_DD],
                  raw_q[CTRL_SHIFT_DD],
                  raw_q[CTRL_SKIP_DD]};

  vectorgen_seq_ctrl_delay #(
    .DEPTH(DLY_DEPTH),
    .WIDTH(3)
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .d    (dly_d),
    .q    (dly_q)
  );

  // pop/shift/skip take the extra two stages
  always_comb begin
    ctrl                = raw_q;
    ctrl[CTRL_POP_DD]   = dly_q[2];
    ctrl[CTRL_SHIFT_DD] = dly_q[1];
    ctrl[CTRL_SKIP_DD]  = dly_q[0];
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_vectorgen_seq_ctrl.sv
// tb_vectorgen_seq_ctrl: scoreboard bench; a loop-nest model
// predicts the per-cycle ctrl/busy/done stream of each pass.
module tb_vectorgen_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, ready;
  logic [9:0] cfg_ih, cfg_ow;
  logic [3:0] cfg_kw, cfg_kh;
  logic [2:0] cfg_pad;
`ifdef VECGEN_SEQ_STALL_EN
  logic       stall = 1'b0;
`endif
  logic [8:0] ctrl;
  logic       busy, done, cfg_err;

  vectorgen_seq_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cfg_ih (cfg_ih),
    .cfg_ow (cfg_ow),
    .cfg_kw (cfg_kw),
    .cfg_kh (cfg_kh),
    .cfg_pad(cfg_pad),
    .ready  (ready),
`ifdef VECGEN_SEQ_STALL_EN
    .stall  (stall),
`endif
    .ctrl   (ctrl),
    .busy   (busy),
    .done   (done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // bits seen one cycle after raw vs three cycles after raw
  localparam logic [8:0] UMASK = 9'h197;
  localparam logic [8:0] DMASK = 9'h068;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [8:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cnt[9];
  int   cnt_done;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic build(int ih, int ow, int kw, int kh,
                       int pad, int w);
    logic [8:0] raw[$];
    logic [8:0] v, a, b;
    int   owt, oh, lo, hi, r;
    bit   sen, p, f, rdd;
    exp_t e;
    owt = ow / 4;
    oh  = ih - kh + 1;
    sen = (kw - 2 * pad) > 4;
    for (int i = 0; i <= w; i++) raw.push_back(9'h002);
    raw.push_back(9'h000);
    for (int i = 0; i < ih; i++) begin
      lo = (i > kh - 1) ? 0 : kh - 1 - i;
      hi = (i > oh - 1) ? kh - 1 - (i - oh + 1) : kh - 1;
      for (int o = 0; o < owt; o++) begin
        for (int h = hi; h >= lo; h--) begin
          for (int c = 0; c < kw; c++) begin
            p   = (c == 0);
            f   = p && (h == hi);
            rdd = f && !(i == 0 && o == 0);
            v    = '0;
            v[6] = p;
            v[5] = !p;
            v[3] = p && h == lo && o == owt - 1
                   && i != ih - 1 && sen;
            v[4] = f && o == 0 && i != 0;
            v[7] = rdd;
            v[2] = rdd && o == owt - 1;
            v[8] = rdd && !(i == ih - 1 && o == owt - 1);
            raw.push_back(v);
          end
        end
      end
    end
    raw.push_back(9'h000);
    raw.push_back(9'h001);
    repeat (6) raw.push_back(9'h000);
    r = raw.size() - 8;
    for (int k = 0; k <= r + 10; k++) begin
      a = (k >= 1 && k - 1 < raw.size()) ? raw[k-1] : '0;
      b = (k >= 3 && k - 3 < raw.size()) ? raw[k-3] : '0;
      e.ctrl = (a & UMASK) | (b & DMASK);
      e.busy = (k <= r + 7);
      e.done = (k == r + 8);
      sb.push_back(e);
    end
  endtask

  task automatic run_pass(string nm, int ih, int ow,
                          int kw, int kh, int pad, int w,
                          int mid_k, int rst_k);
    exp_t e;
    int   k;
    sb.delete();
    build(ih, ow, kw, kh, pad, w);
    for (int i = 0; i < 9; i++) cnt[i] = 0;
    cnt_done = 0;
    cfg_ih  = ih[9:0];
    cfg_ow  = ow[9:0];
    cfg_kw  = kw[3:0];
    cfg_kh  = kh[3:0];
    cfg_pad = pad[2:0];
    ready   = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (rst_k >= 0 && k == rst_k + 1) begin
        chk({nm, "_rst_ctrl"}, 32'(ctrl), 0);
        chk({nm, "_rst_busy"}, 32'(busy), 0);
        chk({nm, "_rst_done"}, 32'(done), 0);
        reset = 1'b0;
        sb.delete();
        break;
      end
      chk({nm, "_cyc"}, 32'({busy, done, ctrl}), 32'(e));
      for (int i = 0; i < 9; i++) cnt[i] += int'(ctrl[i]);
      cnt_done += int'(done);
      if (k == w) ready = 1'b1;
      start = (k == mid_k);
      if (k == rst_k) reset = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
  endtask

  task automatic reject(string nm, int ih, int ow,
                        int kw, int kh);
    cfg_ih  = ih[9:0];
    cfg_ow  = ow[9:0];
    cfg_kw  = kw[3:0];
    cfg_kh  = kh[3:0];
    cfg_pad = 3'd0;
    ready   = 1'b1;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_err"}, 32'(cfg_err), 1);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_ctrl"}, 32'(ctrl), 0);
    @(posedge clk); #1;
    chk({nm, "_err2"}, 32'(cfg_err), 0);
    chk({nm, "_busy2"}, 32'(busy), 0);
    chk({nm, "_ctrl2"}, 32'(ctrl), 0);
  endtask

  task automatic t1_counts(string nm);
    chk({nm, "_pop_dd"}, cnt[6], 18);
    chk({nm, "_shift_dd"}, cnt[5], 36);
    chk({nm, "_skip_dd"}, cnt[3], 0);
    chk({nm, "_nextrow"}, cnt[4], 4);
    chk({nm, "_readdata"}, cnt[7], 9);
    chk({nm, "_nextdata"}, cnt[8], 8);
    chk({nm, "_nextfm"}, cnt[0], 1);
    chk({nm, "_done"}, cnt_done, 1);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    ready   = 1'b0;
    cfg_ih  = '0;
    cfg_ow  = '0;
    cfg_kw  = '0;
    cfg_kh  = '0;
    cfg_pad = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'(ctrl), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(cfg_err), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_pass("t1", 5, 8, 3, 3, 0, 0, -1, -1);
    t1_counts("t1");

    run_pass("t2", 9, 8, 7, 7, 1, 0, -1, -1);
    chk("t2_skip_dd", cnt[3], 8);
    chk("t2_done", cnt_done, 1);

    reject("t3_kh_gt_ih", 3, 8, 3, 4);
    reject("t3_kh0", 5, 8, 3, 0);
    reject("t3_kw0", 5, 8, 0, 3);
    reject("t3_ow0", 5, 0, 3, 3);
    reject("t3_owmod", 5, 6, 3, 3);

    run_pass("t4", 5, 8, 3, 3, 0, 20, -1, -1);
    chk("t4_done", cnt_done, 1);

    run_pass("t5", 5, 8, 3, 3, 0, 0, -1, 20);
    for (int i = 0; i < 3; i++) begin
      chk("t5_idle_done", 32'(done), 0);
      chk("t5_idle_busy", 32'(busy), 0);
      chk("t5_idle_ctrl", 32'(ctrl), 0);
      @(posedge clk); #1;
    end
    run_pass("t5_rerun", 5, 8, 3, 3, 0, 0, -1, -1);
    t1_counts("t5_rerun");

    run_pass("t6", 5, 8, 3, 3, 0, 0, 15, -1);
    t1_counts("t6");

    run_pass("bnd_noskip", 6, 4, 6, 2, 1, 1, -1, -1);
    chk("bnd_noskip_skip", cnt[3], 0);

    run_pass("bnd_kh1", 3, 4, 7, 1, 1, 0, -1, -1);
    chk("bnd_kh1_skip", cnt[3], 2);

    run_pass("bnd_kh_eq_ih", 3, 4, 2, 3, 0, 2, -1, -1);
    chk("bnd_kh_eq_ih_done", cnt_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
